// File: rtl/uart_rx_deserializer_if.sv
// Serial receive bundle: line and enable in, byte plus status flags out.
interface uart_rx_deserializer_if;
  logic       rx_en;
  logic       rx;
  logic [7:0] data_out;
  logic       data_ready;
  logic       parity_error;
  logic       stop_error;
  logic       busy;

  modport master (
    output rx_en, rx,
    input  data_out, data_ready, parity_error, stop_error, busy
  );
  modport slave (
    input  rx_en, rx,
    output data_out, data_ready, parity_error, stop_error, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled 8N1/8E1/8O1 framing with
// mid-bit sampling, parity/stop error flags and a one-cycle ready strobe.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input logic                   clk,
  input logic                   reset,
  uart_rx_deserializer_if.slave bus
);
  localparam int       CW    = $clog2(CLKS_PER_BIT);
  localparam bit       PEN   = (PARITY_EN != 0);
  localparam logic     PODD  = (PARITY_ODD != 0);
  localparam [CW-1:0]  HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam [CW-1:0]  LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          perr, perr_n;
  logic [7:0]    dout, dout_n;
  logic          rdy, rdy_n;
  logic          pe, pe_n;
  logic          se, se_n;
  logic          rx_meta, rx_s, rx_s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      dout    <= '0;
      rdy     <= 1'b0;
      pe      <= 1'b0;
      se      <= 1'b0;
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      perr    <= perr_n;
      dout    <= dout_n;
      rdy     <= rdy_n;
      pe      <= pe_n;
      se      <= se_n;
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    perr_n  = perr;
    dout_n  = dout;
    rdy_n   = 1'b0;
    pe_n    = pe;
    se_n    = se;
    if (state != IDLE && !bus.rx_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: if (bus.rx_en && rx_s_d && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
        // Half-bit check rejects glitches and aligns later samples to mid-bit.
        START: if (cnt == HALF) begin
          cnt_n = '0;
          if (rx_s) state_n = IDLE;
          else begin
            state_n = DATA;
            idx_n   = '0;
            perr_n  = 1'b0;
          end
        end else cnt_n = cnt + 1'b1;
        DATA: if (cnt == LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = PEN ? PARITY : STOP;
        end else cnt_n = cnt + 1'b1;
        PARITY: if (cnt == LAST) begin
          cnt_n   = '0;
          perr_n  = (^shreg) ^ rx_s ^ PODD;
          state_n = STOP;
        end else cnt_n = cnt + 1'b1;
        // Leaving at mid stop bit leaves time to catch a back-to-back start.
        STOP: if (cnt == LAST) begin
          cnt_n   = '0;
          dout_n  = shreg;
          pe_n    = PEN & perr;
          se_n    = ~rx_s;
          rdy_n   = 1'b1;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.data_out     = dout;
  assign bus.data_ready   = rdy;
  assign bus.parity_error = pe;
  assign bus.stop_error   = se;
  assign bus.busy         = (state != IDLE);
endmodule
